// File: rtl/data_mem_responder.sv
// Main-memory responder for the data cache: serves one request at a time,
// returning a 4-word block burst on reads and committing one word on writes.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_last,
  output logic        wr_done,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_WCOMMIT} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [1:0]              beat_q, beat_d;
  logic [31:0]             resp_data_q;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    rd_en;
  logic                    unused_addr;

  logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

  assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      beat_q     <= beat_d;
    end
  end

  // WAIT covers cycles 1..LATENCY-1 so the first beat or commit lands in cycle LATENCY.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    beat_d     = beat_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_write_d = req_write;
          idx_d      = req_addr[ADDR_WIDTH+1:2];
          wdata_d    = req_wdata;
          beat_d     = 2'd0;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = req_write ? S_WCOMMIT : S_BURST;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = is_write_q ? S_WCOMMIT : S_BURST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_BURST: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = S_IDLE;
      end
      S_WCOMMIT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Beat offset is a 2-bit field, so it wraps inside the block by construction.
  assign rd_idx = {idx_d[ADDR_WIDTH-1:2], beat_d};
  assign rd_en  = (state_d == S_BURST) && !rst;

  always_ff @(posedge clk) begin
    if (state_q == S_WCOMMIT && !rst) mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst)        resp_data_q <= '0;
    else if (rd_en) resp_data_q <= mem[rd_idx];
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    resp_valid = (state_q == S_BURST);
    resp_last  = (state_q == S_BURST) && (beat_q == 2'd3);
    wr_done    = (state_q == S_WCOMMIT);
    resp_data  = resp_data_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array model.
module tb_data_mem_responder;
  localparam int AW  = 10;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_last, wr_done, busy;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_m [0:(2**AW)-1];

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
    .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a / 4) % (2**AW);
  endfunction

  // Present a request and wait for the accepting edge; returns with cycle 1 just begun.
  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d, output int waits);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    waits = 0;
    while (req_ready !== 1'b1 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) check("accept_timeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int w;
    send(1'b1, a, d, w);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check("wr_busy_ready", 32'(req_ready), 32'd0);
      check("wr_done", 32'(wr_done), 32'(k == LAT));
      check("wr_no_resp", 32'(resp_valid), 32'd0);
    end
    mem_m[widx(a)] = d;
    @(negedge clk);
    check("wr_ready_back", 32'(req_ready), 32'd1);
    check("wr_done_clear", 32'(wr_done), 32'd0);
    $display("write addr=%08h data=%08h", a, d);
  endtask

  task automatic do_read(input logic [31:0] a, input bit hold, input logic [31:0] na,
                         output int waits);
    int base;
    send(1'b0, a, 32'd0, waits);
    if (hold) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = na;
    end
    base = widx(a) - (widx(a) % 4);
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      check("rd_busy", 32'(busy), 32'd1);
      check("rd_valid", 32'(resp_valid), 32'(k >= LAT));
      check("rd_last", 32'(resp_last), 32'(k == LAT + 3));
      if (k >= LAT) check("rd_data", resp_data, mem_m[base + (k - LAT)]);
    end
    @(negedge clk);
    check("rd_ready_back", 32'(req_ready), 32'd1);
    check("rd_valid_clear", 32'(resp_valid), 32'd0);
    $display("read  addr=%08h base_word=%0d", a, base);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] a, d;
    for (int i = 0; i < 2**AW; i++) mem_m[i] = 32'd0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_last", 32'(resp_last), 32'd0);
    check("rst_wrdone", 32'(wr_done), 32'd0);
    check("rst_data", resp_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // write then block read
    do_write(32'd12, 32'd5);
    do_read(32'd3, 1'b0, 32'd0, w);

    // aligned burst order
    for (int i = 0; i < 4; i++) do_write(32'(64 + 4*i), 32'hA0 + 32'(i));
    do_read(32'h4C, 1'b0, 32'd0, w);

    // request held during a burst is taken only when idle again
    do_read(32'h4C, 1'b1, 32'd8, w);
    do_read(32'd8, 1'b0, 32'd0, w);
    check("held_accept_wait", 32'(w), 32'd0);

    // address wrap
    do_write(32'h1008, 32'h1234);
    do_read(32'd8, 1'b0, 32'd0, w);

    // reset during a pending write drops it
    do_write(32'd0, 32'h77);
    send(1'b1, 32'd0, 32'hDEAD, w);
    @(negedge clk);
    check("abort_wrdone_c1", 32'(wr_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check("abort_wrdone", 32'(wr_done), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
    end
    do_read(32'd0, 1'b0, 32'd0, w);

    // reset during a burst
    send(1'b0, 32'h40, 32'd0, w);
    for (int k = 1; k <= LAT + 1; k++) @(negedge clk);
    check("mid_burst_valid", 32'(resp_valid), 32'd1);
    check("mid_burst_data", resp_data, mem_m[17]);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("burst_rst_valid", 32'(resp_valid), 32'd0);
    check("burst_rst_ready", 32'(req_ready), 32'd1);
    check("burst_rst_last", 32'(resp_last), 32'd0);

    // randomized traffic over a small window with random upper bits
    for (int i = 0; i < 60; i++) begin
      a = $urandom & 32'hFFFF_F0FF;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) do_write(a, d);
      else do_read(a, 1'b0, 32'd0, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
